// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank: per-channel FSM states and
// default sizing constants.
package debounce_pkg;

    localparam int unsigned DEF_CHANNELS      = 16;
    localparam int unsigned DEF_STABLE_CYCLES = 500000;

    // Per-channel debounce state: settled at 0/1 or qualifying a move to 1/0
    typedef enum logic [1:0] {
        ST_STABLE0 = 2'd0,
        ST_WAIT1   = 2'd1,
        ST_STABLE1 = 2'd2,
        ST_WAIT0   = 2'd3
    } state_e;

endpackage

// File: rtl/debounce_bank_if.sv
// Bundle of the debounce bank's per-channel signals.
//   raw_in      : raw switch/button inputs (asynchronous)
//   level       : debounced level per channel
//   rise / fall : one-cycle pulses on debounced level change
//   event_flags : sticky per-channel change flags
//   clr_we      : clear strobe for event_flags
//   clr_mask    : channels cleared when clr_we is high
interface debounce_bank_if
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS
);
    logic [CHANNELS-1:0] raw_in;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] event_flags;
    logic                clr_we;
    logic [CHANNELS-1:0] clr_mask;

    modport master (
        output raw_in, clr_we, clr_mask,
        input  level, rise, fall, event_flags
    );

    modport slave (
        input  raw_in, clr_we, clr_mask,
        output level, rise, fall, event_flags
    );
endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, 4-state qualify FSM with a
// saturating stability counter, registered level and edge pulses.
//   i_clk     : clock
//   i_rst_n   : asynchronous active-low reset
//   i_raw     : raw asynchronous input
//   o_level   : debounced level
//   o_rise    : one-cycle pulse, level 0->1
//   o_fall    : one-cycle pulse, level 1->0
//   o_evt_c   : combinational, high in the cycle whose edge changes level
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_evt_c
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    logic w_s;
    logic w_done;

    assign w_s = r_sync2;

    // Final qualifying cycle: input still at target and counter at its last value
    assign w_done = (r_cnt == CNT_LAST) &&
                    (((r_state == ST_WAIT1) &&  w_s) ||
                     ((r_state == ST_WAIT0) && !w_s));

    // Synchronizer, FSM, counter and edge pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_STABLE0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            case (r_state)
                ST_STABLE0: begin
                    if (w_s) begin
                        r_state <= ST_WAIT1;
                        r_cnt   <= CNT_ONE;
                    end
                end
                ST_WAIT1: begin
                    if (!w_s) begin
                        r_state <= ST_STABLE0;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_STABLE1;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_STABLE1: begin
                    if (!w_s) begin
                        r_state <= ST_WAIT0;
                        r_cnt   <= CNT_ONE;
                    end
                end
                ST_WAIT0: begin
                    if (w_s) begin
                        r_state <= ST_STABLE1;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_STABLE0;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_STABLE0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_evt_c = w_done;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels with shared sticky event flags.
//   clock : sole clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : debounce_bank_if.slave (raw_in, clr_we, clr_mask in;
//           level, rise, fall, event_flags out)
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS      = DEF_CHANNELS,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    debounce_bank_if.slave   bus
);

    logic [CHANNELS-1:0] w_level;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic [CHANNELS-1:0] w_evt;
    logic [CHANNELS-1:0] w_clr;
    logic [CHANNELS-1:0] r_flags;

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .i_clk   (clock),
            .i_rst_n (reset),
            .i_raw   (bus.raw_in[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g]),
            .o_evt_c (w_evt[g])
        );
    end

    assign w_clr = {CHANNELS{bus.clr_we}} & bus.clr_mask;

    // Flags set on the same edge that raises rise/fall; set wins over clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_flags <= '0;
        end else begin
            r_flags <= (r_flags & ~w_clr) | w_evt;
        end
    end

    assign bus.level       = w_level;
    assign bus.rise        = w_rise;
    assign bus.fall        = w_fall;
    assign bus.event_flags = r_flags;

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, default 16, number of independent input channels (1..32).
REQ-002 Parameter STABLE_CYCLES, default 500000, consecutive clock cycles an input must hold a new value before acceptance (2..2^24).
REQ-003 Parameter CNT_W, default $clog2(STABLE_CYCLES), per-channel counter width (derived, not overridden).
REQ-004 The block SHALL use one clock and an asynchronous active-low reset.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 raw_in  in  CHANNELS  asynchronous switch/button inputs.
REQ-008 level  out  CHANNELS  debounced level per channel.
REQ-009 rise  out  CHANNELS  one-cycle pulse when level goes 0->1.
REQ-010 fall  out  CHANNELS  one-cycle pulse when level goes 1->0.
REQ-011 event_flags  out  CHANNELS  sticky per-channel flag, set by any rise or fall.
REQ-012 clr_we  in  1  clear strobe for event_flags.
REQ-013 clr_mask  in  CHANNELS  channels cleared when clr_we=1.

Function
REQ-014 Each raw_in bit SHALL pass a 2-flop synchronizer; the second flop output is "s".
REQ-015 Each channel SHALL run an FSM with states STABLE0, WAIT1, STABLE1, WAIT0.
REQ-016 In STABLE0/STABLE1, the counter is 0; on s differing from level, go to WAIT1/WAIT0 with counter=1.
REQ-017 In WAITx, if s equals the target value, counter increments; when counter reaches STABLE_CYCLES-1 with s still at target, go to STABLEx and update level.
REQ-018 In WAITx, if s reverts to the current level, return to the prior stable state with counter=0 and no change to level, rise, fall.
REQ-019 With raw_in held, level SHALL change on the (STABLE_CYCLES+2)th rising edge after raw_in changes.
REQ-020 rise/fall SHALL assert during the cycle immediately after level changes, for exactly one cycle.
REQ-021 The counter SHALL never exceed STABLE_CYCLES-1 and never wrap.
REQ-022 event_flags[i] SHALL set on the cycle rise[i] or fall[i] is asserted, and remain set until cleared.
REQ-023 clr_we with clr_mask[i]=1 SHALL clear event_flags[i] on the next edge; flags with clr_mask[i]=0 are unaffected.
REQ-024 A simultaneous set and clear on one channel SHALL leave the flag set (set wins).
REQ-025 Channels SHALL be fully independent; simultaneous transitions on any subset are all reported in the same cycle.

Reset
REQ-026 While reset=0: synchronizers=0, all FSMs=STABLE0, counters=0, level=0, rise=0, fall=0, event_flags=0.
REQ-027 Reset mid-WAIT SHALL abort the pending transition with no pulse; after release, a held-high input produces level=1 after STABLE_CYCLES+2 edges.

Structure
REQ-028 Package debounce_pkg SHALL hold the FSM state enum and the default CHANNELS/STABLE_CYCLES constants.
REQ-029 Sub-module debounce_chan SHALL implement one channel (sync, FSM, counter, edge pulses); debounce_bank generates CHANNELS instances plus the shared event_flags/clear logic.

Verification (bench: CHANNELS=4, STABLE_CYCLES=4)
REQ-030 Hold raw_in[0]=1 from reset release -> level[0]=1 on edge 6; rise[0]=1 for exactly one cycle; event_flags=4'b0001.
REQ-031 raw_in[1] toggles 1,0,1,0 on consecutive edges, then holds 0 -> level[1], rise[1], fall[1] stay 0; event_flags[1]=0.
REQ-032 raw_in[2] high for 3 cycles, low for 1, high held -> level[2] rises 6 edges after the final rise only.
REQ-033 event_flags=4'b0101, clr_we=1, clr_mask=4'b0001 in the same cycle that rise[2] re-fires -> event_flags=4'b0100.
REQ-034 reset asserted while channel 3 is in WAIT1 with counter=2 -> all outputs 0 immediately; no rise[3] after release until 6 further edges of held input.
REQ-035 raw_in=4'b1111 simultaneously, then 4'b0000 after settle -> all four rise in one cycle, later all four fall in one cycle.
